// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   SEG_LUT    : hex nibble -> {g,f,e,d,c,b,a} pattern, active-high
//   seg_decode : nibble -> segment pattern
//   lzs_mask   : up to 16 packed nibbles -> per-digit leading-zero blank vector
//   DIG_OFF    : all digit selects released (common-anode, active-low)
//   SEG_OFF    : all segments dark
package seg_scan_pkg;

  localparam logic [15:0]      DIG_OFF = 16'hFFFF;
  localparam logic [6:0]       SEG_OFF = 7'h00;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_LUT = '{
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

  // Bit i (i > 0) is set when nibbles i..15 are all zero. Callers zero-extend
  // narrower displays, so unused upper nibbles never block suppression.
  // Bit 0 stays clear: the units digit is always shown.
  function automatic logic [15:0] lzs_mask(input logic [63:0] nibbles);
    logic [15:0] mask;
    logic        zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = 15; i >= 1; i--) begin
      zero_above = zero_above & (nibbles[4*i +: 4] == 4'h0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_timebase.sv
// Scan timebase: slot prescaler, digit index, frame marker and guard flag.
//   clk_50M, rst_n : clock, asynchronous active-low reset
//   cnt            : position inside the current digit slot, 0..SCAN_DIV-1
//   idx            : digit currently being scanned, 0..N_DIGITS-1
//   slot_end       : last cycle of a slot (combinational)
//   frame_end      : last cycle of the last slot of a frame (combinational)
//   frame_tick     : high for the first cycle after the index wraps to 0
//   guard          : cnt is inside the anti-ghost blanking window
module seg_scan_timebase
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int IDX_W        = $clog2(N_DIGITS),
  parameter int CNT_W        = $clog2(SCAN_DIV)
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_end,
  output logic             frame_end,
  output logic             frame_tick,
  output logic             guard
);

  assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(N_DIGITS - 1));
  assign guard     = (cnt < CNT_W'(GUARD_CYCLES));

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CNT_W'(1);
      frame_tick <= frame_end;
      // Explicit wrap so non-power-of-2 digit counts never reach idx >= N_DIGITS.
      if (slot_end)
        idx <= frame_end ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver for N_DIGITS common-anode digits.
// Optional dimming is enabled by defining SEG_SCAN_DIM_EN.
//   clk_50M, rst_n : clock, asynchronous active-low reset
//   data_in        : packed hex nibbles, digit 0 in data_in[3:0]
//   dp_in          : decimal point per digit, 1 = lit
//   load           : strobe capturing data_in/dp_in for the next frame
//   lzs_en         : leading-zero suppression enable (live)
//   brightness     : 0..15 slot duty (only with SEG_SCAN_DIM_EN)
//   DIG            : active-low digit selects
//   codeout        : active-high segments {g,f,e,d,c,b,a}
//   dp_out         : active-high decimal point segment
//   frame_start    : one-cycle pulse as digit 0's slot begins on the outputs
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int IDX_W        = $clog2(N_DIGITS)
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lzs_en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [N_DIGITS-1:0]   DIG,
  output logic [6:0]            codeout,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_end;
  logic                  frame_tick;
  logic                  guard;

  logic [4*N_DIGITS-1:0] stage_data;
  logic [N_DIGITS-1:0]   stage_dp;
  logic                  pending;
  logic [4*N_DIGITS-1:0] active_data;
  logic [N_DIGITS-1:0]   active_dp;

  logic                  blank_p0;
  logic                  supp_p0;
  logic [3:0]            nib_p0;
  logic [15:0]           lzs_vec_p0;

  seg_scan_timebase #(
    .N_DIGITS    (N_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .GUARD_CYCLES(GUARD_CYCLES),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) u_timebase (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .idx       (idx),
    .slot_end  (slot_end),
    .frame_end (frame_end),
    .frame_tick(frame_tick),
    .guard     (guard)
  );

  // Double buffer: active only changes on the frame-wrap edge, so a frame
  // never mixes old and new digits. A load on that very edge bypasses staging.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      stage_data  <= '0;
      stage_dp    <= '0;
      pending     <= 1'b0;
      active_data <= '0;
      active_dp   <= '0;
    end else if (frame_end) begin
      if (load) begin
        active_data <= data_in;
        active_dp   <= dp_in;
        pending     <= 1'b0;
      end else if (pending) begin
        active_data <= stage_data;
        active_dp   <= stage_dp;
        pending     <= 1'b0;
      end
    end else if (load) begin
      stage_data <= data_in;
      stage_dp   <= dp_in;
      pending    <= 1'b1;
    end
  end

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] bright_q;
  logic [3:0] phase_p0;

  // Captured on the last cycle of a slot so the whole next slot uses one value.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)
      bright_q <= 4'hF;
    else if (slot_end)
      bright_q <= brightness;
  end

  assign phase_p0 = 4'(cnt / CNT_W'(SCAN_DIV / 16));
  assign blank_p0 = guard | (phase_p0 > bright_q);
`else
  assign blank_p0 = guard;
`endif

  assign nib_p0     = active_data[{idx, 2'b00} +: 4];
  assign lzs_vec_p0 = lzs_mask(64'(active_data));
  assign supp_p0    = lzs_en & lzs_vec_p0[idx];

  // Stage p0 -> outputs: everything the pins see is registered here.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      DIG         <= DIG_OFF[N_DIGITS-1:0];
      codeout     <= SEG_OFF;
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DIG         <= blank_p0 ? DIG_OFF[N_DIGITS-1:0] : ~(N_DIGITS'(1) << idx);
      codeout     <= (blank_p0 | supp_p0) ? SEG_OFF : seg_decode(nib_p0);
      dp_out      <= blank_p0 ? 1'b0 : active_dp[idx];
      frame_start <= frame_tick;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 16;
  localparam int GUARD = 2;

  logic          clk_50M = 1'b0;
  logic          rst_n   = 1'b0;
  logic [4*N-1:0] data_in = '0;
  logic [N-1:0]  dp_in   = '0;
  logic          load    = 1'b0;
  logic          lzs_en  = 1'b0;
  logic [3:0]    brightness = 4'hF;
  logic [N-1:0]  DIG;
  logic [6:0]    codeout;
  logic          dp_out;
  logic          frame_start;

  always #5 clk_50M = ~clk_50M;

  seg_scan_driver #(
    .N_DIGITS    (N),
    .SCAN_DIV    (DIV),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .lzs_en     (lzs_en),
`ifdef SEG_SCAN_DIM_EN
    .brightness (brightness),
`endif
    .DIG        (DIG),
    .codeout    (codeout),
    .dp_out     (dp_out),
    .frame_start(frame_start)
  );

  typedef struct {
    logic [3:0] dig;
    logic [6:0] code;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model of the scan state
  int          m_cnt, m_idx;
  logic [15:0] m_stage, m_act;
  logic [3:0]  m_sdp, m_adp;
  logic        m_pend, m_ftick;

  int          cyc;
  int          last_fs;
  logic [7:0]  seen [4];
  int          low_cnt [4];
  int          dp_hi, dp_bad;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_stage = '0; m_act = '0; m_sdp = '0; m_adp = '0;
    m_pend = 1'b0; m_ftick = 1'b0;
    last_fs = -1;
    exp_q.delete();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      seen[i] = 8'hFF;
      low_cnt[i] = 0;
    end
    dp_hi = 0; dp_bad = 0;
  endtask

  // One clock: predict the registered outputs from the current model state,
  // advance the model, then compare after the edge.
  task automatic step();
    exp_t e;
    logic g, supp, boundary;
    logic [3:0] nib;
    g      = (m_cnt < GUARD);
    e.dig  = g ? 4'hF : ~(4'b0001 << m_idx);
    nib    = m_act[m_idx*4 +: 4];
    supp   = lzs_en && (m_idx != 0) && ((m_act >> (4*m_idx)) == 16'h0);
    e.code = (g || supp) ? 7'h00 : seg_ref(nib);
    e.dp   = g ? 1'b0 : m_adp[m_idx];
    e.fs   = m_ftick;
    exp_q.push_back(e);

    boundary = (m_cnt == DIV-1) && (m_idx == N-1);
    if (boundary) begin
      if (load) begin
        m_act = data_in; m_adp = dp_in; m_pend = 1'b0;
      end else if (m_pend) begin
        m_act = m_stage; m_adp = m_sdp; m_pend = 1'b0;
      end
    end else if (load) begin
      m_stage = data_in; m_sdp = dp_in; m_pend = 1'b1;
    end
    m_ftick = boundary;
    if (m_cnt == DIV-1) begin
      m_cnt = 0;
      m_idx = (m_idx == N-1) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end

    @(posedge clk_50M); #1;
    cyc++;
    e = exp_q.pop_front();
    check("DIG", 32'(DIG), 32'(e.dig));
    check("codeout", 32'(codeout), 32'(e.code));
    check("dp_out", 32'(dp_out), 32'(e.dp));
    check("frame_start", 32'(frame_start), 32'(e.fs));

    for (int i = 0; i < 4; i++)
      if (DIG == ~(4'b0001 << i)) begin
        seen[i] = {1'b0, codeout};
        low_cnt[i]++;
      end
    if (dp_out) begin
      dp_hi++;
      if (DIG != 4'b1011) dp_bad++;
    end
    if (frame_start) begin
      if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'd64);
      last_fs = cyc;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next clock edge is the frame-wrap edge.
  task automatic to_boundary();
    int k;
    k = 0;
    while (!((m_cnt == DIV-1) && (m_idx == N-1)) && k < 200) begin
      step();
      k++;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data_in = d; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Load just before a frame wrap, then observe one full following frame.
  task automatic show_frame(input logic [15:0] d, input logic [3:0] dp);
    do_load(d, dp);
    to_boundary();
    step();
    clear_stats();
    steps(64);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk_50M);
    #1;
    check("rst_DIG", 32'(DIG), 32'hF);
    check("rst_code", 32'(codeout), 32'h0);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk_50M);
    rst_n = 1'b1;

    // First digit drive appears on the third edge after release
    steps(2);
    check("guard_c2_DIG", 32'(DIG), 32'hF);
    step();
    check("first_DIG", 32'(DIG), 32'hE);

    // Scan order, duty and decode of 1234
    show_frame(16'h1234, 4'h0);
    for (int i = 0; i < 4; i++) check("low_cycles", 32'(low_cnt[i]), 32'd14);
    check("d0_1234", 32'(seen[0]), 32'h66);
    check("d1_1234", 32'(seen[1]), 32'h4F);
    check("d2_1234", 32'(seen[2]), 32'h5B);
    check("d3_1234", 32'(seen[3]), 32'h06);

    // Mid-frame load holds until the frame boundary
    steps(20);
    do_load(16'hABCD, 4'h0);
    clear_stats();
    to_boundary();
    check("hold_d3", 32'(seen[3]), 32'h06);
    step();
    clear_stats();
    steps(64);
    check("abcd_d0", 32'(seen[0]), 32'h5E);
    check("abcd_d3", 32'(seen[3]), 32'h77);

    // Two loads in one frame: last wins
    steps(5);
    do_load(16'h1111, 4'h0);
    steps(10);
    show_frame(16'h5678, 4'h0);
    check("last_d0", 32'(seen[0]), 32'h7F);
    check("last_d3", 32'(seen[3]), 32'h6D);

    // Load on the boundary edge goes straight to the display
    to_boundary();
    data_in = 16'h9F0E; load = 1'b1;
    step();
    load = 1'b0;
    clear_stats();
    steps(64);
    check("bnd_d0", 32'(seen[0]), 32'h79);
    check("bnd_d1", 32'(seen[1]), 32'h3F);
    check("bnd_d2", 32'(seen[2]), 32'h71);
    check("bnd_d3", 32'(seen[3]), 32'h6F);
    steps(64);
    check("bnd_keep_d0", 32'(seen[0]), 32'h79);

    // Leading-zero suppression
    lzs_en = 1'b1;
    show_frame(16'h0050, 4'h0);
    check("lzs_d3", 32'(seen[3]), 32'h00);
    check("lzs_d2", 32'(seen[2]), 32'h00);
    check("lzs_d1", 32'(seen[1]), 32'h6D);
    check("lzs_d0", 32'(seen[0]), 32'h3F);
    check("lzs_d3_driven", 32'(low_cnt[3]), 32'd14);
    show_frame(16'h0000, 4'h0);
    check("lzs0_d3", 32'(seen[3]), 32'h00);
    check("lzs0_d1", 32'(seen[1]), 32'h00);
    check("lzs0_d0", 32'(seen[0]), 32'h3F);
    lzs_en = 1'b0;
    clear_stats();
    steps(64);
    for (int i = 0; i < 4; i++) check("nolzs", 32'(seen[i]), 32'h3F);

    // Decimal point follows digit 2 only, outside the guard
    lzs_en = 1'b1;
    show_frame(16'h0000, 4'b0100);
    check("dp_hi", 32'(dp_hi), 32'd14);
    check("dp_bad", 32'(dp_bad), 32'd0);
    lzs_en = 1'b0;

    // Asynchronous reset mid-slot, without a clock edge
    while (m_cnt != 8) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_DIG", 32'(DIG), 32'hF);
    check("arst_code", 32'(codeout), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);
    repeat (2) @(posedge clk_50M);
    @(negedge clk_50M);
    rst_n = 1'b1;
    model_reset();
    steps(3);
    check("arst_first_DIG", 32'(DIG), 32'hE);
    check("arst_cleared", 32'(codeout), 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
